// File: rtl/data_mem_ctrl.sv
// Data-memory controller: global RAM, stack RAM and peripheral window.
// Define DMEM_ERR_CAPTURE_EN to add the err_addr/err_cnt capture outputs.
module data_mem_ctrl #(
   parameter logic [19:0] GLOBAL_BASE  = 20'h10010,
   parameter int          GLOBAL_WORDS = 1024,
   parameter logic [19:0] STACK_BASE   = 20'h7ffff,
   parameter int          STACK_WORDS  = 1024,
   parameter logic [19:0] PERI_BASE    = 20'h40000,
   parameter int          WAIT_CYCLES  = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        load_signed,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        err,
   output logic        peri_rd,
   output logic        peri_wr,
   output logic [31:0] peri_addr,
   output logic [31:0] peri_wdata,
   input  logic [31:0] peri_rdata,
   input  logic        peri_acc
`ifdef DMEM_ERR_CAPTURE_EN
   ,
   output logic [31:0] err_addr,
   output logic [7:0]  err_cnt
`endif
);

   localparam int GAW = $clog2(GLOBAL_WORDS);
   localparam int SAW = $clog2(STACK_WORDS);
   localparam logic [10:0] G_LIM = 11'(GLOBAL_WORDS);
   localparam logic [10:0] S_LIM = 11'(1024 - STACK_WORDS);
   localparam logic [3:0] W_LAST = 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS,
      S_RESP
   } state_t;

   typedef enum logic [1:0] {
      R_GLB,
      R_STK,
      R_PERI,
      R_NONE
   } region_t;

   state_t      state_q, state_d;
   region_t     region_q, region_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        sgn_q, sgn_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        bad_q, bad_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
`ifdef DMEM_ERR_CAPTURE_EN
   logic [31:0] eaddr_q, eaddr_d;
   logic [7:0]  ecnt_q, ecnt_d;
`endif

   logic [31:0] gmem [GLOBAL_WORDS];
   logic [31:0] smem [STACK_WORDS];

   logic [19:0] page;
   logic [10:0] idx_in;
   logic        misal;
   logic        dec_bad;
   region_t     region_in;

   // Region and error classification of the incoming request.
   always_comb begin
      page   = addr[31:12];
      idx_in = {1'b0, addr[11:2]};
      misal  = ((size == 2'b01) && addr[0]) ||
               ((size == 2'b10) && (addr[1:0] != 2'b00));
      if ((page == GLOBAL_BASE) && (idx_in < G_LIM)) begin
         region_in = R_GLB;
      end else if ((page == STACK_BASE) && (idx_in >= S_LIM)) begin
         region_in = R_STK;
      end else if (page == PERI_BASE) begin
         region_in = R_PERI;
      end else begin
         region_in = R_NONE;
      end
      dec_bad = misal || (size == 2'b11) || (region_in == R_NONE) ||
                ((region_in == R_PERI) && (size != 2'b10));
   end

   logic [1:0]     off;
   logic [3:0]     be;
   logic [31:0]    wd_al;
   logic [31:0]    rd_word;
   logic [31:0]    sh;
   logic [31:0]    ld_val;
   logic [GAW-1:0] gidx;
   logic [SAW-1:0] sidx;

   always_comb begin
      off  = addr_q[1:0];
      gidx = addr_q[GAW+1:2];
      sidx = addr_q[SAW+1:2];
      case (size_q)
         2'b00: begin
            be    = 4'b0001 << off;
            wd_al = wdata_q << {off, 3'b000};
         end
         2'b01: begin
            be    = 4'b0011 << {off[1], 1'b0};
            wd_al = wdata_q << {off[1], 4'b0000};
         end
         default: begin
            be    = 4'b1111;
            wd_al = wdata_q;
         end
      endcase
   end

   // Load path: pick the source word, move the lane to bit 0, extend.
   always_comb begin
      case (region_q)
         R_GLB:   rd_word = gmem[gidx];
         R_STK:   rd_word = smem[sidx];
         default: rd_word = peri_rdata;
      endcase
      case (size_q)
         2'b00: begin
            sh     = rd_word >> {off, 3'b000};
            ld_val = sgn_q ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
         end
         2'b01: begin
            sh     = rd_word >> {off[1], 4'b0000};
            ld_val = sgn_q ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
         end
         default: begin
            sh     = rd_word;
            ld_val = sh;
         end
      endcase
   end

   always_comb begin
      state_d  = state_q;
      region_d = region_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      size_d   = size_q;
      sgn_d    = sgn_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      bad_d    = bad_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
`ifdef DMEM_ERR_CAPTURE_EN
      eaddr_d  = eaddr_q;
      ecnt_d   = ecnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req) begin
               we_d     = we;
               size_d   = size;
               sgn_d    = load_signed;
               addr_d   = addr;
               wdata_d  = wdata;
               region_d = region_in;
               bad_d    = dec_bad;
               cnt_d    = 4'd0;
               state_d  = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
            end
         end
         S_WAIT: begin
            if (cnt_q == W_LAST) begin
               state_d = S_ACCESS;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_ACCESS: begin
            state_d = S_RESP;
            if (bad_q || ((region_q == R_PERI) && !peri_acc)) begin
               rdata_d = 32'h0;
               err_d   = 1'b1;
`ifdef DMEM_ERR_CAPTURE_EN
               eaddr_d = addr_q;
               if (ecnt_q != 8'hff) begin
                  ecnt_d = ecnt_q + 8'd1;
               end
`endif
            end else begin
               rdata_d = we_q ? 32'h0 : ld_val;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         region_q <= R_NONE;
         cnt_q    <= 4'd0;
         we_q     <= 1'b0;
         size_q   <= 2'b00;
         sgn_q    <= 1'b0;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         bad_q    <= 1'b0;
         rdata_q  <= 32'h0;
         err_q    <= 1'b0;
`ifdef DMEM_ERR_CAPTURE_EN
         eaddr_q  <= 32'h0;
         ecnt_q   <= 8'h0;
`endif
      end else begin
         state_q  <= state_d;
         region_q <= region_d;
         cnt_q    <= cnt_d;
         we_q     <= we_d;
         size_q   <= size_d;
         sgn_q    <= sgn_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         bad_q    <= bad_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
`ifdef DMEM_ERR_CAPTURE_EN
         eaddr_q  <= eaddr_d;
         ecnt_q   <= ecnt_d;
`endif
      end
   end

   logic acc_ok;
   logic g_we;
   logic s_we;

   assign acc_ok = (state_q == S_ACCESS) && !bad_q;
   assign g_we   = acc_ok && we_q && (region_q == R_GLB);
   assign s_we   = acc_ok && we_q && (region_q == R_STK);

   // RAM arrays are deliberately outside reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (g_we && be[i]) begin
            gmem[gidx][8*i +: 8] <= wd_al[8*i +: 8];
         end
         if (s_we && be[i]) begin
            smem[sidx][8*i +: 8] <= wd_al[8*i +: 8];
         end
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign ack        = (state_q == S_RESP);
   assign rdata      = rdata_q;
   assign err        = err_q;
   assign peri_rd    = acc_ok && (region_q == R_PERI) && !we_q;
   assign peri_wr    = acc_ok && (region_q == R_PERI) && we_q;
   assign peri_addr  = addr_q;
   assign peri_wdata = wd_al;
`ifdef DMEM_ERR_CAPTURE_EN
   assign err_addr   = eaddr_q;
   assign err_cnt    = ecnt_q;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized bench for data_mem_ctrl: two instances (0 and 3 wait states)
// share stimulus and are checked against a byte-addressed memory model.
module tb_data_mem_ctrl;

   logic        clk;
   logic        reset;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        load_signed;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] peri_rdata;
   logic        peri_acc;

   logic        busy0, ack0, err0, prd0, pwr0;
   logic [31:0] rdata0, paddr0, pwdata0;
   logic        busy3, ack3, err3, prd3, pwr3;
   logic [31:0] rdata3, paddr3, pwdata3;
`ifdef DMEM_ERR_CAPTURE_EN
   logic [31:0] eaddr0, eaddr3;
   logic [7:0]  ecnt0, ecnt3;
`endif

   data_mem_ctrl #(
      .GLOBAL_WORDS(512),
      .STACK_WORDS (256),
      .WAIT_CYCLES (0)
   ) u_w0 (
      .clk(clk), .reset(reset), .req(req), .we(we),
      .size(size), .load_signed(load_signed),
      .addr(addr), .wdata(wdata),
      .busy(busy0), .ack(ack0), .rdata(rdata0), .err(err0),
      .peri_rd(prd0), .peri_wr(pwr0),
      .peri_addr(paddr0), .peri_wdata(pwdata0),
      .peri_rdata(peri_rdata), .peri_acc(peri_acc)
`ifdef DMEM_ERR_CAPTURE_EN
      , .err_addr(eaddr0), .err_cnt(ecnt0)
`endif
   );

   data_mem_ctrl #(
      .GLOBAL_WORDS(512),
      .STACK_WORDS (256),
      .WAIT_CYCLES (3)
   ) u_w3 (
      .clk(clk), .reset(reset), .req(req), .we(we),
      .size(size), .load_signed(load_signed),
      .addr(addr), .wdata(wdata),
      .busy(busy3), .ack(ack3), .rdata(rdata3), .err(err3),
      .peri_rd(prd3), .peri_wr(pwr3),
      .peri_addr(paddr3), .peri_wdata(pwdata3),
      .peri_rdata(peri_rdata), .peri_acc(peri_acc)
`ifdef DMEM_ERR_CAPTURE_EN
      , .err_addr(eaddr3), .err_cnt(ecnt3)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int nack0 = 0, nack3 = 0;
   int nrd0 = 0, nrd3 = 0;
   int nwr0 = 0, nwr3 = 0;

   always @(posedge clk) begin
      if (ack0) nack0++;
      if (ack3) nack3++;
      if (prd0) nrd0++;
      if (prd3) nrd3++;
      if (pwr0) nwr0++;
      if (pwr3) nwr3++;
   end

   logic [7:0]  mm [bit [31:0]];
   int          ecnt_m = 0;
   logic [31:0] eaddr_m = 32'h0;
   logic [31:0] last_rd0, last_rd3;
   logic        last_err0, last_err3;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int region(input logic [31:0] a);
      logic [9:0] ix;
      ix = a[11:2];
      if (a[31:12] == 20'h10010 && ix < 10'd512) return 0;
      if (a[31:12] == 20'h7ffff && ix >= 10'd768) return 1;
      if (a[31:12] == 20'h40000) return 2;
      return 3;
   endfunction

   task automatic acc(input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic pa, input logic [31:0] pr);
      int rg, nb, l0, l3;
      int a0, a3, r0s, r3s, w0s, w3s;
      bit bad, e;
      logic [31:0] exp_rd, v;
      rg = region(a);
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
            (sz == 2'd2 && a[1:0] != 2'd0) || rg == 3 ||
            (rg == 2 && sz != 2'd2);
      e = bad || (rg == 2 && !pa);
      exp_rd = 32'h0;
      if (!e && !w) begin
         if (rg == 2) begin
            exp_rd = pr;
         end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++)
               v = v | (32'(mm[a + 32'(i)]) << (8 * i));
            if (nb == 1 && sg && v[7]) v = v | 32'hffffff00;
            if (nb == 2 && sg && v[15]) v = v | 32'hffff0000;
            exp_rd = v;
         end
      end
      if (!e && w && rg < 2)
         for (int i = 0; i < nb; i++)
            mm[a + 32'(i)] = wd[8*i +: 8];
      if (e) begin
         if (ecnt_m < 255) ecnt_m++;
         eaddr_m = a;
      end
      a0 = nack0; a3 = nack3;
      r0s = nrd0; r3s = nrd3; w0s = nwr0; w3s = nwr3;
      @(negedge clk);
      we = w; size = sz; load_signed = sg; addr = a; wdata = wd;
      peri_acc = pa; peri_rdata = pr; req = 1'b1;
      @(posedge clk);
      #1 req = 1'b0;
      we = $urandom_range(0, 1); addr = $urandom; size = 2'($urandom);
      l0 = 0; l3 = 0;
      for (int n = 2; n <= 12 && (l0 == 0 || l3 == 0); n++) begin
         @(posedge clk);
         #1;
         if (ack0 && l0 == 0) begin
            l0 = n; last_rd0 = rdata0; last_err0 = err0;
         end
         if (ack3 && l3 == 0) begin
            l3 = n; last_rd3 = rdata3; last_err3 = err3;
         end
      end
      @(posedge clk);
      #1;
      chk("lat_w0", 32'(l0), 32'd2);
      chk("lat_w3", 32'(l3), 32'd5);
      chk("err_w0", {31'h0, last_err0}, {31'h0, e});
      chk("err_w3", {31'h0, last_err3}, {31'h0, e});
      if (e || !w) begin
         chk("rdata_w0", last_rd0, exp_rd);
         chk("rdata_w3", last_rd3, exp_rd);
      end
      chk("ackcnt_w0", 32'(nack0 - a0), 32'd1);
      chk("ackcnt_w3", 32'(nack3 - a3), 32'd1);
      chk("perird_w0", 32'(nrd0 - r0s), 32'(rg == 2 && !bad && !w));
      chk("perird_w3", 32'(nrd3 - r3s), 32'(rg == 2 && !bad && !w));
      chk("periwr_w0", 32'(nwr0 - w0s), 32'(rg == 2 && !bad && w));
      chk("periwr_w3", 32'(nwr3 - w3s), 32'(rg == 2 && !bad && w));
      chk("idle_w0", {31'h0, busy0}, 32'h0);
      chk("idle_w3", {31'h0, busy3}, 32'h0);
      if (rg == 2 && !bad) begin
         chk("paddr_w0", paddr0, a);
         chk("paddr_w3", paddr3, a);
         if (w) begin
            chk("pwdata_w0", pwdata0, wd);
            chk("pwdata_w3", pwdata3, wd);
         end
      end
`ifdef DMEM_ERR_CAPTURE_EN
      chk("errcnt_w0", {24'h0, ecnt0}, 32'(ecnt_m));
      chk("errcnt_w3", {24'h0, ecnt3}, 32'(ecnt_m));
      chk("erraddr_w0", eaddr0, eaddr_m);
      chk("erraddr_w3", eaddr3, eaddr_m);
`endif
   endtask

   logic [31:0] pool [8];
   logic [31:0] unm [4];

   initial begin
      int k;
      logic [31:0] a;
      req = 1'b0; we = 1'b0; size = 2'd0; load_signed = 1'b0;
      addr = 32'h0; wdata = 32'h0; peri_rdata = 32'h0; peri_acc = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {30'h0, busy0, busy3}, 32'h0);
      chk("rst_ack", {30'h0, ack0, ack3}, 32'h0);
      chk("rst_err", {30'h0, err0, err3}, 32'h0);
      chk("rst_rdata0", rdata0, 32'h0);
      chk("rst_rdata3", rdata3, 32'h0);
      chk("rst_peri", {28'h0, prd0, pwr0, prd3, pwr3}, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      acc(1, 2'd2, 0, 32'h10010004, 32'hdeadbeef, 0, 0);
      acc(0, 2'd2, 0, 32'h10010004, 32'h0, 0, 0);
      chk("t1_w0", last_rd0, 32'hdeadbeef);
      chk("t1_w3", last_rd3, 32'hdeadbeef);

      acc(1, 2'd0, 0, 32'h10010006, 32'h00000080, 0, 0);
      acc(0, 2'd0, 1, 32'h10010006, 32'h0, 0, 0);
      chk("t2_sb", last_rd0, 32'hffffff80);
      acc(0, 2'd0, 0, 32'h10010006, 32'h0, 0, 0);
      chk("t2_ub", last_rd3, 32'h00000080);
      acc(0, 2'd2, 0, 32'h10010004, 32'h0, 0, 0);
      chk("t2_word", last_rd0, 32'hde80beef);

      acc(1, 2'd2, 0, 32'h10010000, 32'h11223344, 0, 0);
      acc(1, 2'd2, 0, 32'h7fffff00, 32'h55667788, 0, 0);
      acc(0, 2'd1, 0, 32'h10010001, 32'h0, 0, 0);
      acc(1, 2'd1, 0, 32'h10010001, 32'h0000ffff, 0, 0);
      acc(1, 2'd2, 0, 32'h7fffff02, 32'hffffffff, 0, 0);
      acc(0, 2'd2, 0, 32'h7fffff02, 32'h0, 0, 0);
      chk("t3_err", {31'h0, last_err0}, 32'h1);
      acc(0, 2'd2, 0, 32'h10010000, 32'h0, 0, 0);
      chk("t3_glb", last_rd0, 32'h11223344);
      acc(0, 2'd2, 0, 32'h7fffff00, 32'h0, 0, 0);
      chk("t3_stk", last_rd3, 32'h55667788);

      acc(0, 2'd2, 0, 32'h20000000, 32'h0, 0, 0);
      chk("t4_err", {31'h0, last_err3}, 32'h1);

      acc(0, 2'd2, 0, 32'h40000010, 32'h0, 1, 32'h12);
      chk("t5_rd", last_rd3, 32'h12);
      acc(0, 2'd2, 0, 32'h40000014, 32'h0, 0, 32'h34);
      acc(1, 2'd2, 0, 32'h40000020, 32'hcafef00d, 1, 0);
      acc(1, 2'd2, 0, 32'h40000024, 32'h0badf00d, 0, 0);
      acc(0, 2'd0, 0, 32'h40000008, 32'h0, 1, 32'h99);

      acc(1, 2'd2, 0, 32'h7ffffffc, 32'ha5a5a5a5, 0, 0);
      @(negedge clk);
      we = 1'b1; size = 2'd2; addr = 32'h7ffffffc; wdata = 32'h01020304;
      req = 1'b1;
      @(posedge clk);
      #1 req = 1'b0;
      reset = 1'b1;
      #1;
      chk("t6_busy", {30'h0, busy0, busy3}, 32'h0);
      chk("t6_ack", {30'h0, ack0, ack3}, 32'h0);
      ecnt_m = 0;
      eaddr_m = 32'h0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      acc(0, 2'd2, 0, 32'h7ffffffc, 32'h0, 0, 0);
      chk("t6_word", last_rd0, 32'ha5a5a5a5);

      pool[0] = 32'h10010000; pool[1] = 32'h10010004;
      pool[2] = 32'h100107fc; pool[3] = 32'h10010200;
      pool[4] = 32'h7fffff00; pool[5] = 32'h7ffffffc;
      pool[6] = 32'h7ffffc00; pool[7] = 32'h7ffffe40;
      unm[0] = 32'h10010800; unm[1] = 32'h7ffffbfc;
      unm[2] = 32'h20000000; unm[3] = 32'h00000000;
      for (int i = 0; i < 8; i++)
         acc(1, 2'd2, 0, pool[i], $urandom, 0, 0);
      for (int i = 0; i < 120; i++) begin
         k = $urandom_range(0, 9);
         if (k < 7)
            a = pool[$urandom_range(0, 7)] + 32'($urandom_range(0, 3));
         else if (k == 7)
            a = unm[$urandom_range(0, 3)] + 32'($urandom_range(0, 3));
         else
            a = 32'h40000000 + 32'($urandom_range(0, 4095));
         acc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), a, $urandom,
             ($urandom_range(0, 3) != 0), $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
